// File: rtl/sub_seq.sv
// Byte-serial 32-bit subtractor: one byte per cycle LSB first, result after 4 cycles.
// Optional signed-overflow flag `ovf` is built only when SUB_OVF_EN is defined.
module sub_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] diff,
  output logic        Bout
`ifdef SUB_OVF_EN
  ,
  output logic        ovf
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // `state` is kept as a named signal so checkers can bind to it hierarchically.
  state_t      state;
  state_t      state_next;
  logic [31:0] a_r;
  logic [31:0] b_r;
  logic        borrow;
  logic [1:0]  idx;
  logic [8:0]  byte_sub;
  logic        accept;

  // A new request is taken in IDLE and also in DONE (back-to-back); CALC ignores it.
  assign accept = start && ((state == IDLE) || (state == DONE));

  // Bit 8 of the 9-bit byte difference is the borrow into the next byte.
  assign byte_sub = {1'b0, a_r[{idx, 3'b000} +: 8]}
                  - {1'b0, b_r[{idx, 3'b000} +: 8]}
                  - {8'b0, borrow};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = CALC;
      CALC:    if (idx == 2'd3) state_next = DONE;
      DONE:    state_next = start ? CALC : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == CALC);
    done = (state == DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_r    <= '0;
      b_r    <= '0;
      borrow <= 1'b0;
      idx    <= 2'd0;
      diff   <= '0;
      Bout   <= 1'b0;
`ifdef SUB_OVF_EN
      ovf    <= 1'b0;
`endif
    end else if (accept) begin
      a_r    <= a;
      b_r    <= b;
      borrow <= 1'b0;
      idx    <= 2'd0;
      diff   <= '0;
      Bout   <= 1'b0;
`ifdef SUB_OVF_EN
      ovf    <= 1'b0;
`endif
    end else if (state == CALC) begin
      diff[{idx, 3'b000} +: 8] <= byte_sub[7:0];
      borrow                   <= byte_sub[8];
      idx                      <= idx + 2'd1;
      if (idx == 2'd3) begin
        Bout <= byte_sub[8];
`ifdef SUB_OVF_EN
        // byte_sub[7] is the final diff[31] being written on this same edge.
        ovf  <= (a_r[31] != b_r[31]) && (byte_sub[7] != a_r[31]);
`endif
      end
    end
  end

endmodule

// File: tb/tb_sub_seq.sv
// Bench for sub_seq: directed corner cases plus randomized operations against a
// plain-arithmetic model (a - b, a < b, signed overflow) kept in an expected queue.
module tb_sub_seq;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] diff;
  logic        Bout;
`ifdef SUB_OVF_EN
  logic        ovf;
`endif

  int vectors     = 0;
  int miscompares = 0;

  // Expected entries: {ovf, borrow, diff}
  logic [33:0] exp_q[$];

  sub_seq dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .Bout  (Bout)
`ifdef SUB_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [33:0] model(input logic [31:0] x, input logic [31:0] y);
    logic [31:0] d;
    logic        brw;
    logic        ov;
    d   = x - y;
    brw = (x < y);
    ov  = (x[31] != y[31]) && (d[31] != x[31]);
    return {ov, brw, d};
  endfunction

  // ---------------- drivers (called at a falling edge) ----------------
  task automatic launch(input logic [31:0] x, input logic [31:0] y);
    start = 1'b1;
    a     = x;
    b     = y;
    exp_q.push_back(model(x, y));
  endtask

  // Runs one operation; inject_at >= 0 pulses start with all-ones operands
  // in that CALC cycle. Returns at the falling edge inside the DONE cycle.
  task automatic run_op(input logic [31:0] x, input logic [31:0] y, input int inject_at);
    launch(x, y);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == inject_at) begin
        start = 1'b1;
        a     = 32'hFFFF_FFFF;
        b     = 32'hFFFF_FFFF;
      end else begin
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
      end
      check("busy_calc", {31'b0, busy}, 32'd1);
      check("done_calc", {31'b0, done}, 32'd0);
    end
    @(negedge clk);
    start = 1'b0;
    check("busy_done", {31'b0, busy}, 32'd0);
    check("done_pulse", {31'b0, done}, 32'd1);
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    logic [33:0] e;
    if (done) begin
      if (exp_q.size() == 0) begin
        check("spurious_done", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("diff", diff, e[31:0]);
        check("bout", {31'b0, Bout}, {31'b0, e[32]});
`ifdef SUB_OVF_EN
        check("ovf", {31'b0, ovf}, {31'b0, e[33]});
`endif
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, {31'b0, busy}, 32'd0);
    check({tag, "_done"}, {31'b0, done}, 32'd0);
    check({tag, "_diff"}, diff, 32'd0);
    check({tag, "_bout"}, {31'b0, Bout}, 32'd0);
`ifdef SUB_OVF_EN
    check({tag, "_ovf"}, {31'b0, ovf}, 32'd0);
`endif
  endtask

  task automatic check_idle(input logic [31:0] held);
    check("idle_busy", {31'b0, busy}, 32'd0);
    check("idle_done", {31'b0, done}, 32'd0);
    check("diff_hold", diff, held);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] last;
    reset = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");

    // First start on the first edge after release.
    reset = 1'b0;
    run_op(32'h0000_0005, 32'h0000_0003, -1);
    @(negedge clk);
    check_idle(32'h0000_0002);

    run_op(32'h0000_0000, 32'h0000_0001, -1);
    @(negedge clk);
    check_idle(32'hFFFF_FFFF);

    run_op(32'h8000_0000, 32'h0000_0001, -1);
    @(negedge clk);
    check_idle(32'h7FFF_FFFF);

    // Start during CALC ignored, then back-to-back start in DONE.
    run_op(32'h1234_5678, 32'h0234_5678, 1);
    run_op(32'h0000_0100, 32'h0000_0001, -1);
    @(negedge clk);
    check_idle(32'h0000_00FF);

    // Reset mid-CALC aborts the operation.
    launch(32'h0000_FFFF, 32'h0000_0001);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #2;
    reset = 1'b1;
    void'(exp_q.pop_back());
    #1;
    check_all_zero("abort");
    repeat (3) @(negedge clk);
    check_all_zero("abort_hold");
    reset = 1'b0;
    run_op(32'h0000_FFFF, 32'h0000_0001, -1);
    @(negedge clk);
    check_idle(32'h0000_FFFE);

    // Randomized operations, some back-to-back, some with ignored starts.
    for (int n = 0; n < 40; n++) begin
      x = $urandom;
      case ($urandom_range(0, 3))
        0: y = $urandom;
        1: y = x;
        2: y = x + 32'd1;
        default: begin
          x = $urandom_range(0, 255);
          y = $urandom_range(0, 255);
        end
      endcase
      last = x - y;
      run_op(x, y, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1);
      if ($urandom_range(0, 1) == 1) begin
        @(negedge clk);
        check_idle(last);
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
    end

    repeat (3) @(negedge clk);
    check("queue_empty", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Global time bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    miscompares++;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sub_seq.md
SUB_SEQ -- requirements
Module: sub_seq

Interface
REQ-001 The block SHALL have no parameters; the operand width is fixed at 32 bits.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request to begin one subtraction; sampled on the rising edge of clk.
REQ-005 a  input  32  minuend, unsigned or two's complement; sampled with start.
REQ-006 b  input  32  subtrahend; sampled with start.
REQ-007 busy  output  1  high while a subtraction is in progress.
REQ-008 done  output  1  one-cycle pulse marking that diff/Bout are valid.
REQ-009 diff  output  32  result a - b, modulo 2^32.
REQ-010 Bout  output  1  borrow out; 1 iff a < b unsigned.
REQ-011 ovf  output  1  signed overflow flag; present only when SUB_OVF_EN is defined (see Configuration).

Function
REQ-012 The state machine SHALL have states IDLE, CALC and DONE; reset state is IDLE.
REQ-013 IDLE: start=1 at edge N -> latch a and b, clear the internal borrow and the byte index, go to CALC.
REQ-014 CALC SHALL process one byte per cycle, LSB first. At edges N+1..N+4 it SHALL compute byte k of diff (k = 0..3) as a[k] - b[k] - borrow and update borrow from that byte.
REQ-015 After byte 3 at edge N+4 the block SHALL go to DONE and load Bout from the final borrow.
REQ-016 busy SHALL be 1 from edge N to edge N+4, and 0 otherwise.
REQ-017 done SHALL be 1 for exactly the cycle between edges N+4 and N+5 (the DONE state); total latency is 4 cycles from the start edge.
REQ-018 diff and Bout SHALL hold their values from edge N+4 until the next accepted start or reset. The partial diff SHALL be visible during CALC.
REQ-019 start while in CALC SHALL be ignored, with no effect on the operands or the result.
REQ-020 start=1 in DONE SHALL be accepted: latch new operands, go to CALC, and set busy=1 at that edge (back-to-back operation).
REQ-021 In DONE with start=0, the next state SHALL be IDLE.
REQ-022 Changes to a and b after the start edge SHALL NOT affect the result.
REQ-023 The arithmetic SHALL be exact modulo 2^32, including the borrow ripple across all four bytes (e.g. 0 - 1).

Reset
REQ-024 reset=1 SHALL immediately force the following, regardless of clk: state IDLE, busy=0, done=0, diff=0, Bout=0, ovf=0 (when present), and all internal operand, borrow and index registers to 0.
REQ-025 Reset asserted mid-CALC SHALL abort the operation; no done pulse SHALL follow.
REQ-026 The first start SHALL be accepted on the first rising edge after reset deasserts.

Configuration
REQ-027 Macro SUB_OVF_EN defined: the ovf port SHALL exist and SHALL be loaded at edge N+4 with (a[31] != b[31]) && (diff[31] != a[31]). It SHALL hold with diff and be 0 in reset.
REQ-028 Macro SUB_OVF_EN undefined: the ovf port and its logic SHALL be absent. All other behaviour SHALL be identical.

Verification
REQ-029 a=0x00000005, b=0x00000003, start at edge N -> busy 1 over N..N+4, done 1 only between edges N+4 and N+5, diff=0x00000002, Bout=0.
REQ-030 a=0x00000000, b=0x00000001 -> diff=0xFFFFFFFF, Bout=1, ovf=0.
REQ-031 a=0x80000000, b=0x00000001 -> diff=0x7FFFFFFF, Bout=0; ovf=1 with SUB_OVF_EN; no ovf port without it.
REQ-032 start pulsed at N+2 with a=b=0xFFFFFFFF during an operation on 0x12345678 - 0x02345678 -> ignored; diff=0x10000000. Then start in the DONE cycle with 0x00000100 - 0x00000001 -> busy immediately, diff=0x000000FF four cycles later.
REQ-033 reset asserted at N+2 of an operation on 0x0000FFFF - 0x00000001 -> all outputs 0 at once, no done pulse. A start after reset release -> correct diff=0x0000FFFE.
